// File: rtl/morse_char_assembler_pkg.sv
// ============================================================================
// Module      : morse_pkg
// Description : Shared types and constants for the Morse character assembler:
//               FSM state enum, symbol encoding, default character length
//               and the character record type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

  // Maximum number of symbols a single character may carry
  localparam int MORSE_MAX_SYM = 5;

  // Symbol encoding inside a character code
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Assembler FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  // Completed character record at the default character length
  typedef struct packed {
    logic [MORSE_MAX_SYM-1:0] code;
    logic [2:0]               len;
    logic                     space;
  } char_t;

endpackage

`default_nettype wire

// File: rtl/morse_char_assembler_if.sv
// ============================================================================
// Module      : morse_char_assembler_if
// Description : Valid/ready character channel between the assembler and the
//               downstream lookup/display stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface morse_char_assembler_if
  import morse_pkg::*;
#(
  parameter int MAX_SYM = MORSE_MAX_SYM,
  parameter int LEN_W   = 3
);

  logic               out_valid;
  logic               out_ready;
  logic [MAX_SYM-1:0] out_code;
  logic [LEN_W-1:0]   out_len;
  logic               out_space;

  // Producer side: the assembler drives the character and samples ready
  modport master (
    output out_valid,
    output out_code,
    output out_len,
    output out_space,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_valid,
    input  out_code,
    input  out_len,
    input  out_space,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/morse_char_assembler_slot.sv
// ============================================================================
// Module      : morse_char_slot
// Description : One-entry valid/ready holding register for completed Morse
//               characters. Accepts a load when empty or when the current
//               entry is being popped in the same cycle; otherwise reports the
//               incoming character as dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_char_slot
  import morse_pkg::*;
#(
  parameter int MAX_SYM = MORSE_MAX_SYM,
  parameter int LEN_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_req,
  input  logic [MAX_SYM-1:0] load_code,
  input  logic [LEN_W-1:0]   load_len,
  input  logic               load_space,
  output logic               drop,
  morse_char_assembler_if.master ch
);

  logic               valid_q, valid_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               space_q, space_d;
  logic               load;

  // Load/pop/drop decisions; a pop and a reload may share one cycle
  always_comb begin
    load    = load_req && (!valid_q || ch.out_ready);
    drop    = load_req && valid_q && !ch.out_ready;
    valid_d = valid_q;
    code_d  = code_q;
    len_d   = len_q;
    space_d = space_q;
    if (load) begin
      valid_d = 1'b1;
      code_d  = load_code;
      len_d   = load_len;
      space_d = load_space;
    end else if (valid_q && ch.out_ready) begin
      // Pop: data fields keep their last value
      valid_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      space_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      len_q   <= len_d;
      space_q <= space_d;
    end
  end

  assign ch.out_valid = valid_q;
  assign ch.out_code  = code_q;
  assign ch.out_len   = len_q;
  assign ch.out_space = space_q;

endmodule

`default_nettype wire

// File: rtl/morse_char_assembler.sv
// ============================================================================
// Module      : morse_char_assembler
// Description : Accumulates dot/dash pulses from the Morse decoder into a
//               character code, closes characters on letter/word gaps and
//               hands them to a one-entry valid/ready holding register.
//               Sticky flags report over-long characters and drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int MAX_SYM = MORSE_MAX_SYM,
  parameter int LEN_W   = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dot,
  input  logic dash,
  input  logic lg,
  input  logic wg,
  input  logic err_clr,
  output logic overflow,
  output logic too_long,
  morse_char_assembler_if.master out_if
);

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_COLLECT = 2'(ST_COLLECT);
  localparam logic [1:0] S_ERR     = 2'(ST_ERR);

  logic [1:0]         state_q, state_d;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               too_long_q, too_long_d;
  logic               overflow_q, overflow_d;

  logic               emit;
  logic [MAX_SYM-1:0] emit_code;
  logic [LEN_W-1:0]   emit_len;
  logic               emit_space;
  logic               too_long_set;
  logic               sym;
  logic               drop;

  // FSM and accumulator; priority wg > lg > dash > dot
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    len_d        = len_q;
    emit         = 1'b0;
    emit_code    = code_q;
    emit_len     = len_q;
    emit_space   = 1'b0;
    too_long_set = 1'b0;
    sym          = dash ? SYM_DASH : SYM_DOT;

    case (state_q)
      S_IDLE: begin
        if (wg) begin
          // Word gap with no pending symbols: space-only token
          emit       = 1'b1;
          emit_code  = '0;
          emit_len   = '0;
          emit_space = 1'b1;
        end else if (lg) begin
          // Letter gap without a character carries no information
          state_d = S_IDLE;
        end else if (dot || dash) begin
          code_d    = '0;
          code_d[0] = sym;
          len_d     = LEN_W'(1);
          state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (wg || lg) begin
          emit       = 1'b1;
          emit_code  = code_q;
          emit_len   = len_q;
          emit_space = wg;
          code_d     = '0;
          len_d      = '0;
          state_d    = S_IDLE;
        end else if (dot || dash) begin
          if (len_q < LEN_W'(MAX_SYM)) begin
            for (int i = 0; i < MAX_SYM; i++) begin
              if (len_q == LEN_W'(i)) code_d[i] = sym;
            end
            len_d = len_q + LEN_W'(1);
          end else begin
            // Character too long: discard it and swallow symbols until a gap
            too_long_set = 1'b1;
            code_d       = '0;
            len_d        = '0;
            state_d      = S_ERR;
          end
        end
      end

      S_ERR: begin
        // Any gap ends the discarded character; its word space is lost
        if (wg || lg) state_d = S_IDLE;
      end

      default: begin
        code_d  = '0;
        len_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_comb begin
    too_long_d = (too_long_q && !err_clr) || too_long_set;
    overflow_d = (overflow_q && !err_clr) || drop;
  end

  // FSM, accumulator and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      len_q      <= '0;
      too_long_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      len_q      <= len_d;
      too_long_q <= too_long_d;
      overflow_q <= overflow_d;
    end
  end

  morse_char_slot #(
    .MAX_SYM (MAX_SYM),
    .LEN_W   (LEN_W)
  ) u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_req   (emit),
    .load_code  (emit_code),
    .load_len   (emit_len),
    .load_space (emit_space),
    .drop       (drop),
    .ch         (out_if)
  );

  assign overflow = overflow_q;
  assign too_long = too_long_q;

endmodule

`default_nettype wire

// File: doc/morse_char_assembler.md
# morse_char_assembler

Character assembler and output scheduler for the Morse decoder. It consumes the decoder's single-cycle `dot`, `dash`, `lg` (letter gap) and `wg` (word gap) pulses, accumulates symbols into a character code, and presents completed characters through a one-entry valid/ready holding register. It sits directly downstream of `morse_decoder`, in the same clock domain, and feeds a character lookup or display stage.

## Interface
- `MAX_SYM`, default 5: maximum symbols per character; sets the width of `out_code`.
- `LEN_W`, default 3: width of `out_len`; must satisfy 2^LEN_W > MAX_SYM.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `dot`  in  1  single-cycle pulse from the decoder: dot received.
- `dash`  in  1  single-cycle pulse from the decoder: dash received.
- `lg`  in  1  single-cycle pulse from the decoder: letter gap.
- `wg`  in  1  single-cycle pulse from the decoder: word gap.
- `out_ready`  in  1  consumer accepts the character.
- `err_clr`  in  1  clears the sticky error flags.
- `out_valid`  out  1  holding register contains a character.
- `out_code`  out  MAX_SYM  symbol i at bit i; 1 = dash, 0 = dot; unused bits are 0.
- `out_len`  out  LEN_W  number of symbols, 0..MAX_SYM; 0 means a space-only token.
- `out_space`  out  1  a word gap follows this character.
- `overflow`  out  1  sticky: a character was dropped because the holding register was full.
- `too_long`  out  1  sticky: a character exceeded MAX_SYM symbols and was discarded.

## Operation
- Input priority when pulses coincide: `wg` > `lg` > `dash` > `dot`. The lower-priority pulses in that cycle are ignored.
- FSM states: IDLE, COLLECT, ERR. The state on reset is IDLE.
- IDLE:
  - `dot` or `dash` writes the symbol to bit 0, sets len = 1, and moves to COLLECT.
  - `lg` is ignored.
  - `wg` emits a space token: code 0, len 0, space 1.
- COLLECT:
  - `dot` or `dash` with len < MAX_SYM writes bit[len] and increments len.
  - `dot` or `dash` with len == MAX_SYM sets `too_long`, clears the accumulator, and moves to ERR.
  - `lg` emits (code, len, space 0), clears the accumulator, and moves to IDLE.
  - `wg` emits (code, len, space 1), clears the accumulator, and moves to IDLE.
- ERR:
  - `dot` and `dash` are ignored.
  - `lg` or `wg` moves to IDLE with no emit. The word space is lost.
- Emit and the holding register:
  - An emit loads the register when `!out_valid || out_ready`, which allows a same-cycle pop and reload.
  - Otherwise the character is dropped, the register is unchanged, and `overflow` is set.
  - The accumulator is cleared either way.
- Pop: `out_valid && out_ready` with no load clears `out_valid`. The data fields hold their last value.
- `err_clr` clears `overflow` and `too_long`. If a set event occurs in the same cycle, the set wins.
- Reset mid-character: the accumulator is discarded, the FSM returns to IDLE, and `out_valid` goes to 0.

## Timing
- Reset values: `out_valid`, `out_code`, `out_len`, `out_space`, `overflow` and `too_long` are all 0.
- Latency: an `lg` or `wg` pulse in cycle n gives `out_valid` = 1 in cycle n+1.
- A symbol pulse in cycle n is reflected in the accumulator in cycle n+1.
- `out_*` data fields are stable while `out_valid && !out_ready`.
- Throughput: one character per cycle when `out_ready` is held at 1.
- The error flags assert one cycle after the causing event.

## Structure
- Shared package `morse_pkg`:
  - state enum IDLE/COLLECT/ERR,
  - `MORSE_MAX_SYM` = 5,
  - symbol encoding constants `SYM_DOT` = 0 and `SYM_DASH` = 1,
  - char record type {code, len, space}.
- Sub-module `morse_char_slot`: the one-entry valid/ready holding register, including load, pop and overflow detection.
- The FSM and accumulator live in the top module.

## Test plan
- Send `dot`, `dash`, `lg` with `out_ready` = 1 → `out_code` = 5'b00010, `out_len` = 2, `out_space` = 0, and `out_valid` high for exactly 1 cycle, starting the cycle after `lg`.
- Send `dash` ×4 then `wg` → code 5'b01111, len 4, space 1. A following `wg` from IDLE → space token with len 0, space 1.
- Send 6 `dot`s then `lg` → `too_long` = 1, no emit, FSM back in IDLE. Then `err_clr` → `too_long` = 0. Next `dot`, `lg` → code 0, len 1.
- Hold `out_ready` = 0 and complete two characters, "E" then "T" → "E" held (len 1, code 0) and `overflow` = 1. Raise `out_ready` → "E" popped and `out_valid` = 0.
- With `out_valid` = 1 and `out_ready` = 1 in the same cycle an `lg` completes "T" → "T" loads with no gap cycle and `overflow` stays 0.
- Assert `reset_n` = 0 after 3 symbols → all outputs 0. Release reset, then send `lg` → no emit.
